lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit address and data.
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 core_req_i  input  1  core requests a load/store; held stable with its qualifiers while core_stall_o=1.
REQ-005 core_we_i  input  1  1=store, 0=load.
REQ-006 core_size_i  input  3  funct3 encoding: B=000, H=001, W=010, BU=100, HU=101.
REQ-007 core_addr_i  input  32  byte address.
REQ-008 core_wd_i  input  32  store data, right-aligned.
REQ-009 core_rd_o  output  32  registered load result, aligned and extended.
REQ-010 core_stall_o  output  1  core must hold the request while high.
REQ-011 core_misalign_o  output  1  misaligned-access flag.
REQ-012 mem_req_o, mem_we_o  output  1 each  memory request and write enable.
REQ-013 mem_addr_o  output  32  word-aligned address; bits [1:0] SHALL be 0.
REQ-014 mem_wd_o  output  32  full-word write data.
REQ-015 mem_rd_i  input  32  read data, valid exactly one cycle after a read request.

Function
REQ-016 FSM states SHALL be IDLE, LD_WAIT, RMW_WAIT and DONE.
REQ-017 mem_* outputs SHALL be combinational from the state and core inputs; mem_req_o SHALL be 0 in DONE and while rst_i=1.
REQ-018 core_stall_o SHALL equal core_req_i AND (state != DONE).
REQ-019 IDLE with a load: the block SHALL issue a read (mem_req_o=1, mem_we_o=0) and go to LD_WAIT.
REQ-020 LD_WAIT: the block SHALL select the byte or half from mem_rd_i by addr[1:0], sign-extend it for B/H, zero-extend it for BU/HU, register it into core_rd_o, and go to DONE.
REQ-021 IDLE with a W store: the block SHALL issue a write (mem_we_o=1, mem_wd_o=core_wd_i) and go to DONE, giving a one-cycle stall.
REQ-022 IDLE with a B/H store: the block SHALL issue a read and go to RMW_WAIT.
REQ-023 RMW_WAIT: the block SHALL merge core_wd_i[7:0] or [15:0] into mem_rd_i at lane addr[1:0], issue the write in the same cycle, and go to DONE.
REQ-024 DONE: the stall SHALL be low, the next state SHALL be IDLE, core_req_i SHALL be ignored, and core_rd_o SHALL hold.
REQ-025 Unlisted core_size_i codes (011, 110, 111) SHALL be treated as W.
REQ-026 core_rd_o SHALL change only on a load's LD_WAIT cycle; stores SHALL leave it unchanged.
REQ-027 If core_req_i drops in LD_WAIT or RMW_WAIT (a protocol violation), the block SHALL still complete to DONE; an RMW write still occurs.
REQ-028 Memory read data returned during a write cycle SHALL be ignored.

Reset
REQ-029 When rst_i=1 the state SHALL go to IDLE and core_rd_o and core_misalign_o SHALL become 0, including mid-operation; an RMW in progress SHALL issue no write.

Configuration
REQ-030 With LSU_MISALIGN_EN defined, the following accesses SHALL be misaligned:
- H/HU with addr[0]=1.
- W with addr[1:0] != 0.
REQ-031 With LSU_MISALIGN_EN defined, a misaligned access SHALL issue no memory request and go IDLE to DONE; core_misalign_o SHALL be 1 in DONE only, and core_rd_o SHALL hold.
REQ-032 Without LSU_MISALIGN_EN:
- core_misalign_o SHALL be tied to 0.
- Halves SHALL use addr[1] only.
- Words SHALL ignore addr[1:0].

Structure
REQ-033 Package lsu_pkg SHALL hold the size-code constants and the FSM state enum.
REQ-034 Load alignment and extension SHALL be a combinational sub-module, lsu_load_align.

Verification
Memory word at 0x100 preloaded to 0x8081_7F02.
REQ-035 Byte loads SHALL return these results:
- LB 0x101 returns 0x0000_007F.
- LB 0x103 returns 0xFFFF_FF80.
- LBU 0x103 returns 0x0000_0080.
- In every case the stall is 2 cycles and the result is valid in DONE.
REQ-036 Half loads at 0x102 SHALL return these results:
- LH returns 0xFFFF_8081.
- LHU returns 0x0000_8081.
REQ-037 SB 0x102, wd 0x0000_00AA SHALL produce a read of 0x100, then a write of 0x80AA_7F02 to 0x100; the stall is 2 cycles.
REQ-038 SW 0x104, wd 0xDEAD_BEEF SHALL produce a single write cycle; the stall is 1 cycle and core_rd_o is unchanged.
REQ-039 SH 0x100 with rst_i asserted in RMW_WAIT SHALL produce no write; the word stays 0x8081_7F02 and state is IDLE.
REQ-040 LW 0x102 with LSU_MISALIGN_EN SHALL produce no mem_req_o and core_misalign_o=1 for one cycle; without the macro it SHALL return 0x8081_7F02.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states
// and the store-merge helper.
package lsu_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    LD_WAIT,
    RMW_WAIT,
    DONE
  } lsu_state_e;

  function automatic logic is_byte(input logic [2:0] size);
    return (size == SIZE_B) || (size == SIZE_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] size);
    return (size == SIZE_H) || (size == SIZE_HU);
  endfunction

  // Any code that is neither a byte nor a half access behaves as a word.
  function automatic logic is_word(input logic [2:0] size);
    return !is_byte(size) && !is_half(size);
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [2:0]  size,
                                              input logic [1:0]  offset);
    logic [31:0] merged;
    merged = word;
    if (is_byte(size)) begin
      merged[{offset, 3'b000} +: 8] = wd[7:0];
    end else if (is_half(size)) begin
      merged[{offset[1], 4'b0000} +: 16] = wd[15:0];
    end else begin
      merged = wd;
    end
    return merged;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half from a fetched word and sign- or
// zero-extends it; word accesses pass through untouched.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SIZE_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      SIZE_BU: data_o = {24'd0, byte_sel};
      SIZE_H:  data_o = {{16{half_sel[15]}}, half_sel};
      SIZE_HU: data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between the core and a word-wide memory with one-cycle read
// latency; sub-word stores use read-modify-write. Option: LSU_MISALIGN_EN.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  lsu_state_e  state_q, state_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] load_data;
  logic        misaligned;

  lsu_load_align u_load_align (
    .size_i   (core_size_i),
    .offset_i (core_addr_i[1:0]),
    .word_i   (mem_rd_i),
    .data_o   (load_data)
  );

`ifdef LSU_MISALIGN_EN
  logic misalign_q, misalign_d;

  assign misaligned = (is_half(core_size_i) && core_addr_i[0]) ||
                      (is_word(core_size_i) && (core_addr_i[1:0] != 2'b00));
  // Set only on the IDLE->DONE hop, so it is visible for the DONE cycle alone.
  assign misalign_d = (state_q == IDLE) && core_req_i && misaligned;
  assign core_misalign_o = misalign_q;
`else
  assign misaligned      = 1'b0;
  assign core_misalign_o = 1'b0;
`endif

  assign mem_addr_o   = {core_addr_i[31:2], 2'b00};
  assign core_stall_o = core_req_i && (state_q != DONE);
  assign core_rd_o    = rd_q;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_wd_o  = core_wd_i;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (misaligned) begin
            state_d = DONE;
          end else if (!core_we_i) begin
            mem_req_o = 1'b1;
            state_d   = LD_WAIT;
          end else if (is_word(core_size_i)) begin
            mem_req_o = 1'b1;
            mem_we_o  = 1'b1;
            state_d   = DONE;
          end else begin
            mem_req_o = 1'b1;
            state_d   = RMW_WAIT;
          end
        end
      end
      LD_WAIT: begin
        rd_d    = load_data;
        state_d = DONE;
      end
      // Completes even if the core dropped its request: the read already went out.
      RMW_WAIT: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        mem_wd_o  = store_merge(mem_rd_i, core_wd_i, core_size_i, core_addr_i[1:0]);
        state_d   = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rd_q       <= '0;
`ifdef LSU_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
`ifdef LSU_MISALIGN_EN
      misalign_q <= misalign_d;
`endif
    end
  end

endmodule
